// File: rtl/seq_counter.sv
// Programmable-table sequence counter: walks a DEPTH-entry table forward or backward,
// wrapping at a run-time last index, with synchronous load, table write and reset.
module seq_counter #(
  parameter int unsigned              WIDTH = 4,
  parameter int unsigned              DEPTH = 8,
  parameter logic [DEPTH*WIDTH-1:0]   INIT  = 32'h068E1F9F,
  localparam int unsigned             AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             C,
  input  logic             R,
  input  logic             EN,
  input  logic             DIR,
  input  logic [AW-1:0]    LAST,
  input  logic             LD,
  input  logic [AW-1:0]    LDIDX,
  input  logic             WE,
  input  logic [AW-1:0]    WA,
  input  logic [WIDTH-1:0] WD,
  output logic [WIDTH-1:0] Q,
  output logic [AW-1:0]    IDX,
  output logic             WRAP
);

  localparam logic [AW-1:0] MaxIdx = AW'(DEPTH - 1);
  localparam logic [31:0]   DepthW = 32'(DEPTH);

  logic [WIDTH-1:0] r_table [DEPTH];
  logic [AW-1:0]    r_idx;
  logic             r_wrap;

  logic [AW-1:0]    w_last;
  logic [AW-1:0]    w_idx_next;
  logic             w_wrap_next;
  logic             w_wa_ok;

  // Out-of-range LAST only exists when DEPTH is not a power of two.
  always_comb begin
    w_last = LAST;
    if (32'(LAST) >= DepthW) begin
      w_last = MaxIdx;
    end
  end

  assign w_wa_ok = (32'(WA) < DepthW);

  always_comb begin
    w_idx_next  = r_idx;
    w_wrap_next = 1'b0;
    if (LD) begin
      w_idx_next = (LDIDX > w_last) ? w_last : LDIDX;
    end else if (EN) begin
      if (!DIR) begin
        if (r_idx >= w_last) begin
          w_idx_next  = '0;
          w_wrap_next = 1'b1;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end else begin
        if (r_idx == '0) begin
          w_idx_next  = w_last;
          w_wrap_next = 1'b1;
        end else if (r_idx > w_last) begin
          // Index stranded above a freshly lowered LAST: snap back without a wrap.
          w_idx_next = w_last;
        end else begin
          w_idx_next = r_idx - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge C) begin
    if (R) begin
      r_idx  <= '0;
      r_wrap <= 1'b0;
      for (int k = 0; k < int'(DEPTH); k++) begin
        r_table[k] <= INIT[k*WIDTH +: WIDTH];
      end
    end else begin
      if (WE && w_wa_ok) begin
        r_table[WA] <= WD;
      end
      r_idx  <= w_idx_next;
      r_wrap <= w_wrap_next;
    end
  end

  assign Q    = r_table[r_idx];
  assign IDX  = r_idx;
  assign WRAP = r_wrap;

endmodule

// File: tb/tb_seq_counter.sv
// Bench for seq_counter: directed scenarios plus random traffic, checked against a
// table/index reference model built from the counter's stepping rules.
module tb_seq_counter;

  logic       C = 1'b0;
  logic       R, EN, DIR, LD, WE;
  logic [2:0] LAST, LDIDX, WA;
  logic [3:0] WD;
  logic [3:0] Q;
  logic [2:0] IDX;
  logic       WRAP;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_tab [8];
  int m_idx;
  bit m_wrap;
  logic [31:0] init_v = 32'h068E1F9F;

  seq_counter dut (
    .C     (C),
    .R     (R),
    .EN    (EN),
    .DIR   (DIR),
    .LAST  (LAST),
    .LD    (LD),
    .LDIDX (LDIDX),
    .WE    (WE),
    .WA    (WA),
    .WD    (WD),
    .Q     (Q),
    .IDX   (IDX),
    .WRAP  (WRAP)
  );

  always #5 C = ~C;

  task automatic model_edge();
    int l;
    l = (int'(LAST) > 7) ? 7 : int'(LAST);
    if (R) begin
      m_idx  = 0;
      m_wrap = 0;
      for (int k = 0; k < 8; k++) m_tab[k] = int'(init_v[k*4 +: 4]);
    end else begin
      if (WE && int'(WA) < 8) m_tab[WA] = int'(WD);
      m_wrap = 0;
      if (LD) begin
        m_idx = (int'(LDIDX) < l) ? int'(LDIDX) : l;
      end else if (EN && !DIR) begin
        // Forward: past or at the end of the lap means start a new lap.
        if (m_idx >= l) begin m_idx = 0; m_wrap = 1; end
        else m_idx = m_idx + 1;
      end else if (EN && DIR) begin
        if (m_idx == 0) begin m_idx = l; m_wrap = 1; end
        else if (m_idx > l) m_idx = l;
        else m_idx = m_idx - 1;
      end
    end
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".idx"}, int'(IDX), m_idx);
    check({tag, ".q"}, int'(Q), m_tab[m_idx]);
    check({tag, ".wrap"}, int'(WRAP), int'(m_wrap));
  endtask

  task automatic cyc(input logic r, input logic ld, input logic [2:0] ldidx, input logic en,
                     input logic dir, input logic [2:0] last, input logic we,
                     input logic [2:0] wa, input logic [3:0] wd, input string tag);
    R = r; LD = ld; LDIDX = ldidx; EN = en; DIR = dir; LAST = last;
    WE = we; WA = wa; WD = wd;
    model_edge();
    @(posedge C);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 7, 0, 0, 0, "reset");
  endtask

  initial begin
    int exp1 [10] = '{15, 9, 15, 1, 14, 8, 6, 0, 15, 9};
    int exp2 [6]  = '{0, 3, 2, 1, 0, 3};
    R = 0; EN = 0; DIR = 0; LD = 0; WE = 0; LAST = 7; LDIDX = 0; WA = 0; WD = 0;
    @(posedge C);
    #1;

    // 1: default forward sequence
    do_reset();
    check("t1.q0", int'(Q), exp1[0]);
    check("t1.wrap0", int'(WRAP), 0);
    for (int i = 1; i < 10; i++) begin
      cyc(0, 0, 0, 1, 0, 7, 0, 0, 0, "t1");
      check($sformatf("t1.q%0d", i), int'(Q), exp1[i]);
      check($sformatf("t1.wrap%0d", i), int'(WRAP), (i == 8) ? 1 : 0);
    end

    // 2: backward, LAST=3
    do_reset();
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 0, 1, 1, 3, 0, 0, 0, "t2");
      check($sformatf("t2.idx%0d", i), int'(IDX), exp2[i]);
      check($sformatf("t2.wrap%0d", i), int'(WRAP), (exp2[i] == 3) ? 1 : 0);
    end

    // 3: write entry 2 while stepping onto it
    do_reset();
    cyc(0, 0, 0, 1, 0, 7, 0, 0, 0, "t3.pre");
    cyc(0, 0, 0, 1, 0, 7, 1, 2, 5, "t3.wr");
    check("t3.idx", int'(IDX), 2);
    check("t3.q", int'(Q), 5);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 0, 7, 0, 0, 0, "t3.lap");
    check("t3.lap_q", int'(Q), 5);

    // 4: load clamped to LAST beats EN
    do_reset();
    cyc(0, 1, 6, 1, 0, 4, 0, 0, 0, "t4.ld");
    check("t4.idx", int'(IDX), 4);
    check("t4.q", int'(Q), 14);
    check("t4.wrap", int'(WRAP), 0);
    cyc(0, 0, 0, 1, 0, 4, 0, 0, 0, "t4.step");
    check("t4.idx2", int'(IDX), 0);
    check("t4.wrap2", int'(WRAP), 1);

    // 5: LAST lowered below IDX
    do_reset();
    cyc(0, 1, 6, 0, 0, 7, 0, 0, 0, "t5.ld");
    cyc(0, 0, 0, 1, 0, 2, 0, 0, 0, "t5.fwd");
    check("t5.fwd_idx", int'(IDX), 0);
    check("t5.fwd_wrap", int'(WRAP), 1);
    cyc(0, 1, 6, 0, 0, 7, 0, 0, 0, "t5.ld2");
    cyc(0, 0, 0, 1, 1, 2, 0, 0, 0, "t5.bwd");
    check("t5.bwd_idx", int'(IDX), 2);
    check("t5.bwd_wrap", int'(WRAP), 0);

    // 6: reset with concurrent write restores INIT
    do_reset();
    cyc(0, 0, 0, 0, 0, 7, 1, 0, 3, "t6.wr");
    check("t6.q_wr", int'(Q), 3);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 7, 0, 0, 0, "t6.run");
    check("t6.idx5", int'(IDX), 5);
    cyc(1, 0, 0, 1, 0, 7, 1, 0, 7, "t6.rst");
    check("t6.idx", int'(IDX), 0);
    check("t6.q", int'(Q), 15);
    check("t6.wrap", int'(WRAP), 0);

    // One-entry sequence
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 1, i[0], 0, 0, 0, 0, "l0");
      check("l0.wrap", int'(WRAP), 1);
    end

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) == 0), 3'($urandom),
          ($urandom_range(0, 3) != 0), 1'($urandom), 3'($urandom),
          ($urandom_range(0, 2) == 0), 3'($urandom), 4'($urandom), "rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised arbitrary-sequence counter: steps through a programmable table of DEPTH values of WIDTH bits each, forward or backward, wrapping at a run-time-selectable last index. It replaces the hard-wired gate-level sequence counters in the computer lab designs. Changing the sequence only requires a table write, not new next-state logic. The default table reproduces the lab sequence 15, 9, 15, 1, 14, 8, 6, 0.

## Interface
- WIDTH, 4: bits per sequence value.
- DEPTH, 8: table entries (≥2); AW = clog2(DEPTH) is the index width.
- INIT, 32'h068E1F9F: packed reset contents, DEPTH*WIDTH bits; entry k is INIT[k*WIDTH +: WIDTH]. The default gives entries 0..7 = 15, 9, 15, 1, 14, 8, 6, 0.

Ports:
- C  in  1  clock; all state updates on the rising edge.
- R  in  1  synchronous reset, active-high.
- EN  in  1  advance one step this cycle.
- DIR  in  1  0 = forward (index up), 1 = backward (index down).
- LAST  in  AW  index of the final step, sampled every cycle; values ≥DEPTH are treated as DEPTH-1.
- LD  in  1  synchronous jump to LDIDX.
- LDIDX  in  AW  jump target.
- WE  in  1  table write strobe.
- WA  in  AW  table write address.
- WD  in  WIDTH  table write data.
- Q  out  WIDTH  current value, TABLE[IDX], decoded combinationally from registers.
- IDX  out  AW  current index (registered).
- WRAP  out  1  registered one-cycle pulse for a step that wrapped.

## Operation
- State: the IDX register, the TABLE register array and the WRAP register.
- Let L = min(LAST, DEPTH-1).
- Priority at each edge: R > LD > EN.
  - R: IDX=0, TABLE=INIT, WRAP=0. WE is ignored in the same cycle.
  - LD: IDX = min(LDIDX, L), WRAP=0.
  - EN with DIR=0:
    - if IDX ≥ L: IDX=0 and WRAP=1;
    - otherwise IDX+1 and WRAP=0.
  - EN with DIR=1:
    - if IDX=0: IDX=L and WRAP=1;
    - if IDX>L: IDX=L and WRAP=0;
    - otherwise IDX-1 and WRAP=0.
  - No action: IDX holds, WRAP=0.
- Table write: when WE=1 and R=0, TABLE[WA]=WD at the edge. It is independent of LD and EN. WA ≥ DEPTH is ignored.
- Simultaneous write and step: both take effect. After the edge, Q = new TABLE[new IDX].
- Lowering LAST below IDX mid-run:
  - forward: the next EN step wraps to 0 with WRAP=1;
  - backward: the next EN step goes to L with no WRAP.
- L=0 gives a one-entry sequence. Each EN step keeps IDX=0 and pulses WRAP.
- Q never shows X after reset; TABLE is fully initialised by R.

## Timing
- Output values after reset: IDX=0, Q=INIT entry 0 (15 by default), WRAP=0.
- Step latency: one edge. Q changes in the same cycle as IDX, with no extra output register.
- WRAP is high for exactly the cycle after the wrapping edge. Consecutive wrapping steps give consecutive pulses.
- A table write is visible on Q in the cycle after the edge if WA=IDX. There is no read-during-write bypass before the edge.
- Reset mid-sequence: the next cycle shows IDX=0 and Q=INIT[0]. Any rewritten entries revert to INIT.
- Single clock domain; all inputs are synchronous to C.

## Test plan
1. Default sequence:
   - Stimulus: R for 1 cycle, then EN=1, DIR=0, LAST=7 for 10 cycles.
   - Required: Q = 15, 9, 15, 1, 14, 8, 6, 0, 15, 9. WRAP is high only in the cycle Q returns to 15.
2. Backward with short length:
   - Stimulus: R, LAST=3, DIR=1, EN=1.
   - Required: IDX = 0, 3, 2, 1, 0, 3. Q = 15, 1, 15, 9, 15, 1. WRAP is high in the cycles showing IDX=3.
3. Write during step:
   - Stimulus: from IDX=1, EN=1, WE=1, WA=2, WD=5.
   - Required: the next cycle shows IDX=2, Q=5. The entry persists on the next lap.
4. Jump and clamp:
   - Stimulus: LAST=4, LD=1, LDIDX=6, EN=1 in the same cycle.
   - Required: IDX=4, Q=14, WRAP=0. The next EN step gives IDX=0, WRAP=1.
5. LAST lowered below IDX:
   - Stimulus: at IDX=6, LAST becomes 2; step forward, then separately step backward from IDX=6.
   - Required: forward gives IDX=0 with WRAP=1; backward gives IDX=2 with WRAP=0.
6. Reset mid-run with a modified table:
   - Stimulus: write entry 0 with 3, run to IDX=5, assert R together with WE (WA=0, WD=7).
   - Required: IDX=0, Q=15, WRAP=0; the write is ignored.
